// File: rtl/piano_pkg.sv
// Shared definitions for the piano voice: note indices, tone table, half-period derivation, segment codes.
// PIANO_SIM_FAST_EN shrinks every half-period by 1000x so simulations reach tone edges quickly.
package piano_pkg;

    typedef enum logic [3:0] {
        NOTE_C4,
        NOTE_D4,
        NOTE_E4,
        NOTE_F4,
        NOTE_G4,
        NOTE_A4,
        NOTE_B4,
        NOTE_C5,
        NOTE_NONE
    } note_e;

    localparam int NUM_NOTES = 8;
    localparam int HP_W      = 32;

    // Note pitches in centihertz, C4 first.
    localparam int unsigned NOTE_FREQ_CHZ [NUM_NOTES] = '{
        26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;

    localparam logic [7:0] SEG_LETTER [NUM_NOTES] = '{
        8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h88, 8'h83, 8'hC6
    };

    // Rounded clk_hz / (2 * f); only ever evaluated on constants.
    function automatic logic [HP_W-1:0] hp_calc(input longint clk_hz, input int idx);
        longint fc;
        longint hp;
        fc = longint'(NOTE_FREQ_CHZ[idx]);
        hp = (clk_hz * 100 + fc) / (2 * fc);
`ifdef PIANO_SIM_FAST_EN
        hp = hp / 1000;
`endif
        return hp[HP_W-1:0];
    endfunction

endpackage

// File: rtl/piano_tone_div.sv
// Square-wave divider: counts to the half-period, wraps and toggles the tone output.
// A clear or a disable forces the counter and tone low so every new tone starts in low phase.
module piano_tone_div
    import piano_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [HP_W-1:0] hp,
    input  logic            enable,
    input  logic            clear,
    output logic            freq
);

    logic [HP_W-1:0] cnt;
    logic [HP_W:0]   cnt_inc;
    logic            wrap;

    // A zero half-period degenerates to toggling every cycle instead of stalling.
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign wrap    = (cnt_inc >= {1'b0, hp});

    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            cnt  <= '0;
            freq <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            freq <= ~freq;
        end else begin
            cnt  <= cnt_inc[HP_W-1:0];
        end
    end

endmodule

// File: rtl/piano_top.sv
// Single-note piano voice: key switches to square-wave tone, note LED and 4-digit note/octave display.
// Build option PIANO_SIM_FAST_EN: half-periods divided by 1000 and display scan counter fixed at 4 bits.
module piano_top
    import piano_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_BITS = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MODE,
    input  logic [7:0] sw,
    output logic       FREQ,
    output logic [7:0] Led,
    output logic [7:0] seg,
    output logic [3:0] an
);

`ifdef PIANO_SIM_FAST_EN
    localparam int RB = 4;
`else
    localparam int RB = REFRESH_BITS;
`endif

    logic [7:0]      sw_s1, sw_s2;
    logic            mode_s1, mode_s2;
    note_e           note_d, note_q;
    logic            mode_q;
    logic [2:0]      note_idx;
    logic            active;
    logic            sel_change;
    logic [HP_W-1:0] hp_tab [NUM_NOTES];
    logic [HP_W-1:0] hp_eff;
    logic [RB-1:0]   ref_cnt;
    logic [1:0]      dig;
    logic [7:0]      seg_d;
    logic [3:0]      an_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            note_q  <= NOTE_NONE;
            mode_q  <= 1'b0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            mode_s1 <= MODE;
            mode_s2 <= mode_s1;
            note_q  <= note_d;
            mode_q  <= mode_s2;
        end
    end

    // Scanning upward lets the highest set switch (lowest pitch) win.
    always_comb begin
        note_d = NOTE_NONE;
        for (int i = 0; i < 8; i++) begin
            if (sw_s2[i]) note_d = note_e'(4'(7 - i));
        end
    end

    assign sel_change = (note_d != note_q) || (mode_s2 != mode_q);
    assign note_idx   = note_q[2:0];
    assign active     = (note_q != NOTE_NONE);
    assign Led        = active ? (8'h80 >> note_idx) : 8'h00;

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_hp
        assign hp_tab[i] = hp_calc(longint'(CLK_HZ), i);
    end

    assign hp_eff = mode_q ? hp_tab[note_idx] : (hp_tab[note_idx] >> 1);

    piano_tone_div u_tone_div (
        .clk    (CLK),
        .reset  (RESET),
        .hp     (hp_eff),
        .enable (active),
        .clear  (sel_change),
        .freq   (FREQ)
    );

    assign dig = ref_cnt[RB-1 -: 2];

    always_comb begin
        an_d  = ~(4'b0001 << dig);
        seg_d = SEG_BLANK;
        if (active) begin
            if (dig == 2'd3) begin
                seg_d = SEG_LETTER[note_idx];
            end else if (dig == 2'd2) begin
                if (note_idx == 3'd7) seg_d = mode_q ? SEG_5 : SEG_6;
                else                  seg_d = mode_q ? SEG_4 : SEG_5;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ref_cnt <= '0;
            seg     <= SEG_BLANK;
            an      <= 4'b1110;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            seg     <= seg_d;
            an      <= an_d;
        end
    end

endmodule

// File: tb/tb_piano_top.sv
// Bench for piano_top: directed scenarios plus random key/mode traffic against a cycle-indexed reference model.
// Uses a low CLK_HZ in the default build so tone half-periods stay short.
module tb_piano_top;

`ifdef PIANO_SIM_FAST_EN
    localparam int CLK_HZ_TB = 100_000_000;
`else
    localparam int CLK_HZ_TB = 100_000;
`endif
    localparam int RB_TB = 4;
    localparam int HIST  = 32768;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       MODE;
    logic [7:0] sw;
    logic       FREQ;
    logic [7:0] Led;
    logic [7:0] seg;
    logic [3:0] an;

    piano_top #(.CLK_HZ(CLK_HZ_TB), .REFRESH_BITS(RB_TB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .MODE  (MODE),
        .sw    (sw),
        .FREQ  (FREQ),
        .Led   (Led),
        .seg   (seg),
        .an    (an)
    );

    always #5 CLK = ~CLK;

    real        freq_hz    [8] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25};
    logic [7:0] letter_seg [8] = '{8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h88, 8'h83, 8'hC6};

    logic [7:0] sw_at   [HIST];
    logic       mode_at [HIST];
    int         cyc       = 0;
    int         last_rst  = 0;
    int         start     = 0;
    int         prev_note = 8;
    logic       prev_mode = 1'b0;
    int         errors    = 0;
    int         checks    = 0;

    // Lowest pitch among the pressed keys, 8 when none.
    function automatic int pick_note(input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (s[7-i]) return i;
        end
        return 8;
    endfunction

    function automatic int hp_model(input int note, input logic mode);
        int hp;
        hp = $rtoi(real'(CLK_HZ_TB) / (2.0 * freq_hz[note]) + 0.5);
`ifdef PIANO_SIM_FAST_EN
        hp = hp / 1000;
`endif
        if (!mode) hp = hp / 2;
        return hp;
    endfunction

    function automatic logic [7:0] octave_seg(input int note, input logic mode);
        int octave;
        octave = (note == 7) ? 5 : 4;
        if (!mode) octave = octave + 1;
        case (octave)
            4:       return 8'h99;
            5:       return 8'h92;
            default: return 8'h82;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int         note_n;
        logic       mode_n;
        int         t;
        int         dig;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic [7:0] exp_led;
        logic       exp_freq;
        @(posedge CLK);
        cyc++;
        if (cyc >= HIST) begin
            $display("FAIL history_overflow cycles=%0d limit=%0d", cyc, HIST);
            $fatal(1, "history exhausted");
        end
        sw_at[cyc]   = sw;
        mode_at[cyc] = MODE;
        if (RESET) last_rst = cyc;
        // Selection seen after edge n comes from the inputs present at edge n-2.
        if (cyc - 2 <= last_rst) begin
            note_n = 8;
            mode_n = 1'b0;
        end else begin
            note_n = pick_note(sw_at[cyc-2]);
            mode_n = mode_at[cyc-2];
        end
        t = cyc - last_rst;
        if (t == 0) begin
            exp_an  = 4'b1110;
            exp_seg = 8'hFF;
        end else begin
            dig     = ((t - 1) >> (RB_TB - 2)) & 3;
            exp_an  = ~(4'b0001 << dig);
            exp_seg = 8'hFF;
            if (prev_note < 8 && dig == 3) exp_seg = letter_seg[prev_note];
            if (prev_note < 8 && dig == 2) exp_seg = octave_seg(prev_note, prev_mode);
        end
        if (t == 0 || note_n != prev_note || mode_n != prev_mode) start = cyc;
        exp_freq = (note_n < 8) ? (((cyc - start) / hp_model(note_n, mode_n)) % 2 == 1) : 1'b0;
        exp_led  = (note_n < 8) ? (8'h80 >> note_n) : 8'h00;
        prev_note = note_n;
        prev_mode = mode_n;
        @(negedge CLK);
        check("freq", {31'd0, FREQ}, {31'd0, exp_freq});
        check("led",  {24'd0, Led},  {24'd0, exp_led});
        check("an",   {28'd0, an},   {28'd0, exp_an});
        check("seg",  {24'd0, seg},  {24'd0, exp_seg});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits for one tone edge, then counts cycles to the following edge.
    task automatic measure(input string tag, input int exp_hp);
        int   n;
        logic f0;
        n  = 0;
        f0 = FREQ;
        while (FREQ === f0 && n < 4000) begin
            tick();
            n++;
        end
        n  = 0;
        f0 = FREQ;
        while (FREQ === f0 && n < 4000) begin
            tick();
            n++;
        end
        check(tag, n, exp_hp);
    endtask

    initial begin
        RESET = 1'b1;
        MODE  = 1'b1;
        sw    = 8'h00;
        @(negedge CLK);
        run(3);
        check("reset_an",  {28'd0, an},  32'h0000_000E);
        check("reset_seg", {24'd0, seg}, 32'h0000_00FF);

        RESET = 1'b0;
        run(20);

        sw = 8'b0010_0000;
        run(2);
        check("led_before_latency", {24'd0, Led}, 32'h0000_0000);
        tick();
        check("led_e4_latency", {24'd0, Led}, 32'h0000_0020);
        measure("e4_half_period_mode1", hp_model(2, 1'b1));
        run(20);

        MODE = 1'b0;
        run(4);
        measure("e4_half_period_mode0", hp_model(2, 1'b0));
        run(20);

        MODE = 1'b1;
        sw   = 8'b1000_1000;
        run(4);
        check("led_c4_priority", {24'd0, Led}, 32'h0000_0080);
        measure("c4_half_period", hp_model(0, 1'b1));

        sw = 8'b0010_0000;
        run(hp_model(2, 1'b1) / 2 + 3);
        sw = 8'b0001_0000;
        run(3);
        check("f4_switch_freq_low", {31'd0, FREQ}, 32'd0);
        run(2 * hp_model(3, 1'b1) + 10);

        RESET = 1'b1;
        tick();
        check("midtone_reset_freq", {31'd0, FREQ}, 32'd0);
        check("midtone_reset_led",  {24'd0, Led},  32'd0);
        check("midtone_reset_an",   {28'd0, an},   32'h0000_000E);
        RESET = 1'b0;
        run(2 * hp_model(3, 1'b1) + 10);

        for (int p = 0; p < 25; p++) begin
            case ($urandom_range(0, 3))
                0:       sw = 8'h00;
                1:       sw = 8'h01 << $urandom_range(0, 7);
                default: sw = 8'($urandom);
            endcase
            MODE = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                RESET = 1'b1;
                run(2);
                RESET = 1'b0;
            end
            run($urandom_range(10, 350));
        end

        sw = 8'h00;
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
